// File: rtl/bpf_seq.sv
// bpf_seq: power-up / calibrate / monitor sequencer for the band-pass filter block.
// Outputs are decoded from the next state so they switch on the same edge as the state.
`timescale 1ns/1ps
module bpf_seq #(
    parameter int T_SETTLE = 10,
    parameter int TIMEOUT  = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        RDY_BPF,
    output logic        PU_BPF,
    output logic        CAL_BPF,
    output logic        BPF_OK,
    output logic        BPF_ERR,
    output logic        BUSY,
    output logic [15:0] CAL_CYCLES
);
    localparam logic [2:0] OFF   = 3'd0;
    localparam logic [2:0] PWRUP = 3'd1;
    localparam logic [2:0] CAL   = 3'd2;
    localparam logic [2:0] READY = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;
    localparam logic [15:0] SETTLE_LD = 16'(T_SETTLE - 1);
    localparam logic [15:0] TMO_LD    = 16'(TIMEOUT - 1);

    logic [2:0]  state, nxt;
    logic [15:0] settle, tmo, cyc, cyc_inc;

    assign cyc_inc = &cyc ? cyc : cyc + 16'd1;

    // EN low wins over every other transition
    always_comb
        nxt = !EN             ? OFF :
              state == OFF    ? PWRUP :
              state == PWRUP  ? (|settle ? PWRUP : CAL) :
              state == CAL    ? (RDY_BPF ? READY : |tmo ? CAL : FAULT) :
              state == READY  ? (RDY_BPF ? READY : FAULT) :
              state == FAULT  ? FAULT : OFF;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= OFF;
            settle     <= '0;
            tmo        <= '0;
            cyc        <= '0;
            CAL_CYCLES <= '0;
            PU_BPF     <= 1'b0;
            CAL_BPF    <= 1'b0;
            BPF_OK     <= 1'b0;
            BPF_ERR    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state   <= nxt;
            PU_BPF  <= nxt == PWRUP || nxt == CAL || nxt == READY;
            CAL_BPF <= nxt == CAL;
            BPF_OK  <= nxt == READY;
            BPF_ERR <= nxt == FAULT;
            BUSY    <= nxt == PWRUP || nxt == CAL;
            settle  <= state != PWRUP ? SETTLE_LD : |settle ? settle - 16'd1 : settle;
            tmo     <= state != CAL ? TMO_LD : |tmo ? tmo - 16'd1 : tmo;
            cyc     <= state != CAL ? 16'd0 : cyc_inc;
            // an abort via EN low leaves the last recorded count untouched
            if (state == CAL && EN && nxt != CAL)
                CAL_CYCLES <= cyc_inc;
        end
    end
endmodule

// File: tb/tb_bpf_seq.sv
// tb_bpf_seq: randomized scoreboard bench for bpf_seq, two parameter sets sharing one stimulus stream.
`timescale 1ns/1ps
module tb_bpf_seq;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, rdy = 1'b0;
    logic pu_a, cal_a, ok_a, err_a, busy_a, pu_b, cal_b, ok_b, err_b, busy_b;
    logic [15:0] cc_a, cc_b;
    logic [20:0] act_a, act_b;
    logic [20:0] qa[$], qb[$];
    int tests = 0, fails = 0;
    int bcnt = 0;
    logic bpf_rdy = 1'b0, rnd_rdy = 1'b0;

    typedef enum {M_OFF, M_PU, M_CAL, M_RDY, M_FLT} ph_t;
    typedef struct {ph_t ph; int t; int cc;} mdl_t;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    bpf_seq dut_a (.CLK(clk), .RST(rst), .EN(en), .RDY_BPF(rdy), .PU_BPF(pu_a), .CAL_BPF(cal_a),
                   .BPF_OK(ok_a), .BPF_ERR(err_a), .BUSY(busy_a), .CAL_CYCLES(cc_a));
    bpf_seq #(.T_SETTLE(3), .TIMEOUT(30)) dut_b (.CLK(clk), .RST(rst), .EN(en), .RDY_BPF(rdy),
                   .PU_BPF(pu_b), .CAL_BPF(cal_b), .BPF_OK(ok_b), .BPF_ERR(err_b), .BUSY(busy_b),
                   .CAL_CYCLES(cc_b));

    assign act_a = {pu_a, cal_a, ok_a, err_a, busy_a, cc_a};
    assign act_b = {pu_b, cal_b, ok_b, err_b, busy_b, cc_b};

    // BPF model: ready 40 calibrate cycles after CAL rises, held while powered
    always @(posedge clk) begin
        bcnt <= cal_a ? bcnt + 1 : 0;
        bpf_rdy <= pu_a && (bpf_rdy || (cal_a && bcnt >= 40));
    end

    // t counts cycles spent in the current phase; cc is the last recorded calibration length
    function automatic mdl_t step(mdl_t m, int ts, int to, bit e, bit r);
        mdl_t n = m;
        if (!e) n.ph = M_OFF;
        else case (m.ph)
            M_OFF: begin n.ph = M_PU; n.t = 1; end
            M_PU:  if (m.t == ts) begin n.ph = M_CAL; n.t = 0; end else n.t = m.t + 1;
            M_CAL: begin
                n.t = m.t < 65535 ? m.t + 1 : 65535;
                if (r) begin n.ph = M_RDY; n.cc = n.t; end
                else if (n.t == to) begin n.ph = M_FLT; n.cc = n.t; end
            end
            M_RDY: if (!r) n.ph = M_FLT;
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [20:0] outs(mdl_t m);
        return {m.ph inside {M_PU, M_CAL, M_RDY}, m.ph == M_CAL, m.ph == M_RDY, m.ph == M_FLT,
                m.ph inside {M_PU, M_CAL}, 16'(m.cc)};
    endfunction

    task automatic chk(string name, logic [20:0] act, logic [20:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got pu,cal,ok,err,busy=%b cc=%0d, want %b cc=%0d",
                     name, $time, act[20:16], act[15:0], exp[20:16], exp[15:0]);
        end
    endtask

    // mode: 0 BPF model, 1 low, 2 high, 3 sticky random
    task automatic drive(bit e, int mode);
        @(negedge clk);
        if ($urandom_range(0, 99) < 4) rnd_rdy = ~rnd_rdy;
        en = e;
        rdy = mode == 0 ? bpf_rdy : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : rnd_rdy;
        @(posedge clk);
        ma = step(ma, 10, 64, e, rdy);
        mb = step(mb, 3, 30, e, rdy);
        qa.push_back(outs(ma));
        qb.push_back(outs(mb));
    endtask

    // called right after a drive, so the pulse lands between clock edges
    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1 chk("async_rst_a", act_a, 21'd0);
        chk("async_rst_b", act_b, 21'd0);
        qa.delete();
        qb.delete();
        ma = '{ph: M_OFF, t: 0, cc: 0};
        mb = '{ph: M_OFF, t: 0, cc: 0};
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) if (!rst) begin
        if (qa.size() != 0) chk("seq_a", act_a, qa.pop_front());
        if (qb.size() != 0) chk("seq_b", act_b, qb.pop_front());
        tests++;
        if ((cal_a && !pu_a) || (ok_a && err_a) || (cal_b && !pu_b) || (ok_b && err_b)) begin
            fails++;
            $display("FAIL invariant @%0t: a=%b b=%b", $time, act_a[20:16], act_b[20:16]);
        end
    end

    initial begin
        ma = '{ph: M_OFF, t: 0, cc: 0};
        mb = '{ph: M_OFF, t: 0, cc: 0};
        #12 chk("reset_a", act_a, 21'd0);
        chk("reset_b", act_b, 21'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) drive(0, 3);
        repeat (70) drive(1, 0);
        #1 chk("boot_ok_a", act_a, {5'b10100, 16'd42});
        chk("timeout_b", act_b, {5'b00010, 16'd30});
        drive(1, 1);
        #1 chk("rdy_loss_a", act_a, {5'b00010, 16'd42});
        drive(0, 1);
        #1 chk("off_a", act_a, {5'b00000, 16'd42});
        chk("off_b", act_b, {5'b00000, 16'd30});
        repeat (30) drive(1, 1);
        #1 chk("in_cal_a", act_a, {5'b11001, 16'd42});
        drive(0, 1);
        #1 chk("abort_a", act_a, {5'b00000, 16'd42});
        chk("abort_b", act_b, {5'b00000, 16'd30});
        repeat (33) drive(1, 1);
        drive(1, 2);
        #1 chk("rdy_at_timeout_b", act_b, {5'b10100, 16'd30});
        chk("ready_early_a", act_a, {5'b10100, 16'd23});
        drive(0, 1);
        repeat (15) drive(1, 1);
        rst_pulse();
        repeat (70) drive(1, 0);
        #1 chk("reboot_ok_a", act_a, {5'b10100, 16'd42});
        chk("reboot_timeout_b", act_b, {5'b00010, 16'd30});
        repeat (3000) begin
            drive($urandom_range(0, 99) < 98, 3);
            if ($urandom_range(0, 499) == 0) rst_pulse();
        end
        @(negedge clk);
        #1 tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d expectations left unchecked", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
